// File: rtl/tcbnn_axis_pkg.sv
// Shared AXI-Stream geometry and FSM state type for the binary NN core datapath
// (byte packer, core input and result collector).
package tcbnn_axis_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int BYTE_WIDTH  = 8;
  localparam int LANES       = DATA_WIDTH / BYTE_WIDTH;
  localparam int FRAME_BYTES = 784;
  localparam int BEATS       = FRAME_BYTES / LANES;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } axis_state_e;

  // Counter width that stays legal (>= 1 bit) even for a range of one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_beat_counter.sv
// Counts handshaked beats within a frame, flags the final beat and pulses
// frame_done for one cycle after that final beat completes.
module axis_beat_counter #(
  parameter int BEATS = tcbnn_axis_pkg::BEATS,
  parameter int CNT_W = tcbnn_axis_pkg::cnt_width(tcbnn_axis_pkg::BEATS)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic beat_fire,
  output logic is_last,
  output logic frame_done
);

  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W-1:0] beat_cnt_d;
  logic             frame_done_q;
  logic             frame_done_d;

  assign is_last    = (beat_cnt_q == CNT_W'(BEATS - 1));
  assign frame_done = frame_done_q;

  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    frame_done_d = 1'b0;
    if (clr) begin
      beat_cnt_d   = '0;
      frame_done_d = 1'b0;
    end else if (beat_fire) begin
      if (is_last) begin
        beat_cnt_d   = '0;
        frame_done_d = 1'b1;
      end else begin
        beat_cnt_d   = beat_cnt_q + CNT_W'(1);
        frame_done_d = 1'b0;
      end
    end else begin
      beat_cnt_d   = beat_cnt_q;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: rtl/img_axis_packer.sv
// Packs a byte-wide pixel stream into LANES-byte AXI-Stream beats (lane 0 first)
// and marks the last beat of every FRAME_BYTES-byte image.
module img_axis_packer #(
  parameter int DATA_WIDTH  = tcbnn_axis_pkg::DATA_WIDTH,
  parameter int BYTE_WIDTH  = tcbnn_axis_pkg::BYTE_WIDTH,
  parameter int FRAME_BYTES = tcbnn_axis_pkg::FRAME_BYTES
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [BYTE_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic                  frame_done
);

  import tcbnn_axis_pkg::*;

  localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int NUM_BEATS = FRAME_BYTES / NUM_LANES;
  localparam int LANE_W    = cnt_width(NUM_LANES);
  localparam int BEAT_W    = cnt_width(NUM_BEATS);

  axis_state_e           state_q;
  axis_state_e           state_d;
  logic [LANE_W-1:0]     lane_cnt_q;
  logic [LANE_W-1:0]     lane_cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  valid_q;
  logic                  valid_d;
  logic                  last_q;
  logic                  last_d;
  logic                  run_q;
  logic                  in_ready_s;
  logic                  byte_fire_s;
  logic                  beat_fire_s;
  logic                  beat_is_last_s;

  // run_q keeps in_ready low while reset is held and for the first edge after.
  assign in_ready_s  = run_q & ~flush & ((state_q == COLLECT) | m_axis_ready);
  assign byte_fire_s = in_valid & in_ready_s;
  assign beat_fire_s = valid_q & m_axis_ready;

  assign in_ready     = in_ready_s;
  assign m_axis_valid = valid_q;
  assign m_axis_data  = data_q;
  assign m_axis_last  = last_q;

  axis_beat_counter #(
    .BEATS (NUM_BEATS),
    .CNT_W (BEAT_W)
  ) u_beat_counter (
    .clk        (axi_clk),
    .rst        (axi_reset),
    .clr        (flush),
    .beat_fire  (beat_fire_s),
    .is_last    (beat_is_last_s),
    .frame_done (frame_done)
  );

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    if (flush) begin
      state_d    = COLLECT;
      lane_cnt_d = '0;
      data_d     = '0;
      valid_d    = 1'b0;
      last_d     = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (byte_fire_s) begin
            data_d[int'(lane_cnt_q)*BYTE_WIDTH +: BYTE_WIDTH] = in_data;
            if (lane_cnt_q == LANE_W'(NUM_LANES - 1)) begin
              lane_cnt_d = '0;
              state_d    = HOLD;
              valid_d    = 1'b1;
              last_d     = beat_is_last_s;
            end else begin
              lane_cnt_d = lane_cnt_q + LANE_W'(1);
            end
          end else begin
            lane_cnt_d = lane_cnt_q;
          end
        end
        HOLD: begin
          if (beat_fire_s) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = COLLECT;
            // A byte taken on the handshake cycle already starts the next word.
            if (byte_fire_s) begin
              data_d[BYTE_WIDTH-1:0] = in_data;
              lane_cnt_d             = LANE_W'(1);
            end else begin
              lane_cnt_d = '0;
            end
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d    = COLLECT;
          lane_cnt_d = '0;
          valid_d    = 1'b0;
          last_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q    <= COLLECT;
      lane_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      run_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_img_axis_packer.sv
// Self-checking bench for img_axis_packer: a byte-queue reference model checks
// every beat, plus a vector table and directed corner-case sequences.
module tb_img_axis_packer;

  localparam int NB = 196;

  logic        axi_clk = 1'b0;
  logic        axi_reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        m_axis_valid;
  logic [31:0] m_axis_data;
  logic        m_axis_ready = 1'b0;
  logic        m_axis_last;
  logic        frame_done;

  img_axis_packer dut (
    .axi_clk      (axi_clk),
    .axi_reset    (axi_reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .m_axis_valid (m_axis_valid),
    .m_axis_data  (m_axis_data),
    .m_axis_ready (m_axis_ready),
    .m_axis_last  (m_axis_last),
    .frame_done   (frame_done)
  );

  always #5 axi_clk = ~axi_clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  mq[$];
  int          beat_idx = 0;
  int          beats_seen = 0;
  int          bytes_acc = 0;
  int          fd_seen = 0;
  logic        fd_exp = 1'b0;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_data = 32'h0;
  logic        prev_last = 1'b0;
  logic [31:0] last_data = 32'h0;
  logic        last_last = 1'b0;
  int          lastq[$];

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        mr;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic        eir;
    logic        efd;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, then advance the model.
  task automatic cyc(input logic iv, input logic [7:0] d, input logic mr, input logic fl);
    logic fd_next;
    @(negedge axi_clk);
    in_valid = iv; in_data = d; m_axis_ready = mr; flush = fl;
    #1;
    chk("frame_done", {31'b0, frame_done}, {31'b0, fd_exp});
    chk("m_axis_valid", {31'b0, m_axis_valid}, {31'b0, mq.size() >= 4});
    if (!fl) chk("in_ready", {31'b0, in_ready}, {31'b0, (mq.size() < 4) || mr});
    if (hold_prev) begin
      chk("hold_data", m_axis_data, prev_data);
      chk("hold_last", {31'b0, m_axis_last}, {31'b0, prev_last});
    end
    fd_next = 1'b0;
    if (m_axis_valid && mr && mq.size() >= 4) begin
      chk("beat_data", m_axis_data, {mq[3], mq[2], mq[1], mq[0]});
      chk("beat_last", {31'b0, m_axis_last}, {31'b0, beat_idx == NB - 1});
      if (m_axis_last) lastq.push_back(beats_seen);
      last_data = m_axis_data;
      last_last = m_axis_last;
      beats_seen++;
      repeat (4) void'(mq.pop_front());
      if (beat_idx == NB - 1) begin
        beat_idx = 0;
        fd_next = !fl;
      end else begin
        beat_idx++;
      end
    end
    hold_prev = m_axis_valid && !mr && !fl;
    prev_data = m_axis_data;
    prev_last = m_axis_last;
    if (iv && in_ready && !fl) begin
      mq.push_back(d);
      bytes_acc++;
    end
    if (fl) begin
      mq.delete();
      beat_idx = 0;
      fd_next = 1'b0;
    end
    if (frame_done) fd_seen++;
    fd_exp = fd_next;
  endtask

  task automatic apply_reset();
    @(negedge axi_clk);
    #3;
    axi_reset = 1'b1; in_valid = 1'b0; m_axis_ready = 1'b0; flush = 1'b0;
    #1;
    chk("rst_valid", {31'b0, m_axis_valid}, 32'd0);
    chk("rst_data", m_axis_data, 32'd0);
    chk("rst_last", {31'b0, m_axis_last}, 32'd0);
    chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge axi_clk);
    @(negedge axi_clk);
    axi_reset = 1'b0;
    mq.delete();
    beat_idx = 0; fd_exp = 1'b0; hold_prev = 1'b0;
    @(posedge axi_clk);
  endtask

  task automatic feed(input int n, input int v0, input logic mr);
    int got;
    got = 0;
    for (int c = 0; c < 4 * n + 40 && got < n; c++) begin
      int b0;
      b0 = bytes_acc;
      cyc(1'b1, 8'(v0 + got), mr, 1'b0);
      if (bytes_acc != b0) got++;
    end
    chk("feed_count", got, n);
  endtask

  initial begin
    int b_start;
    int f_start;

    tbl[0] = '{1'b1, 8'h01, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'h02, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'h03, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h04, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 32'h04030201, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};

    apply_reset();

    // First word, vector table
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].iv, tbl[i].d, tbl[i].mr, 1'b0);
      chk("tbl_valid", {31'b0, m_axis_valid}, {31'b0, tbl[i].ev});
      chk("tbl_in_ready", {31'b0, in_ready}, {31'b0, tbl[i].eir});
      chk("tbl_frame_done", {31'b0, frame_done}, {31'b0, tbl[i].efd});
      if (tbl[i].ev) begin
        chk("tbl_data", m_axis_data, tbl[i].ed);
        chk("tbl_last", {31'b0, m_axis_last}, {31'b0, tbl[i].el});
      end
    end

    // Back-pressure for 10 cycles, then byte 0x05 on the release cycle
    apply_reset();
    feed(4, 1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'h05, 1'b0, 1'b0);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    cyc(1'b1, 8'h05, 1'b1, 1'b0);
    chk("bp_release_beat", last_data, 32'h04030201);
    feed(3, 6, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("bp_next_beat", last_data, 32'h08070605);

    // Full frame, ready always high
    apply_reset();
    b_start = beats_seen; f_start = fd_seen;
    feed(784, 0, 1'b1);
    repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("frame_beats", beats_seen - b_start, 196);
    chk("frame_last_data", last_data, 32'h0F0E0D0C);
    chk("frame_last_flag", {31'b0, last_last}, 32'd1);
    chk("frame_done_count", fd_seen - f_start, 1);

    // Flush after two bytes of beat 7
    apply_reset();
    f_start = fd_seen;
    feed(30, 0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    cyc(1'b1, 8'hBB, 1'b1, 1'b0);
    cyc(1'b1, 8'hCC, 1'b1, 1'b0);
    cyc(1'b1, 8'hDD, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_beat0_data", last_data, 32'hDDCCBBAA);
    chk("flush_beat0_last", {31'b0, last_last}, 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_no_frame_done", fd_seen - f_start, 0);

    // Flush on the same cycle as the last-beat handshake
    apply_reset();
    f_start = fd_seen;
    feed(780, 0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    feed(4, 12, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("flush_hs_last", {31'b0, last_last}, 32'd1);
    repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_hs_no_frame_done", fd_seen - f_start, 0);

    // Random valid/ready over three frames
    apply_reset();
    b_start = beats_seen; f_start = fd_seen;
    lastq.delete();
    begin
      int target;
      target = bytes_acc + 3 * 784;
      for (int c = 0; c < 30000 && (beats_seen - b_start) < 588; c++)
        cyc((bytes_acc < target) && ($urandom_range(3) != 0), 8'($urandom),
            $urandom_range(2) != 0, 1'b0);
    end
    repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rand_beats", beats_seen - b_start, 588);
    chk("rand_frame_done", fd_seen - f_start, 3);
    chk("rand_last_count", lastq.size(), 3);
    if (lastq.size() == 3) begin
      chk("rand_last0", lastq[0] - b_start, 195);
      chk("rand_last1", lastq[1] - b_start, 391);
      chk("rand_last2", lastq[2] - b_start, 587);
    end

    // Asynchronous reset while holding a beat
    apply_reset();
    feed(4, 8'h40, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_async_valid", {31'b0, m_axis_valid}, 32'd1);
    apply_reset();
    b_start = beats_seen;
    feed(4, 8'h10, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_reset_beats", beats_seen - b_start, 1);
    chk("post_reset_data", last_data, 32'h13121110);
    chk("post_reset_last", {31'b0, last_last}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
